// File: rtl/game_flow_controller.sv
// Snake game sequencer: idle/play/pause/over FSM, one-cycle game reset, move-tick timer and level.
// Define GFC_SPEEDUP_EN to shorten the move-tick period as apples are eaten.
module game_flow_controller #(
  parameter int TICK_BASE   = 1200000,
  parameter int TICK_STEP   = 100000,
  parameter int TICK_MIN    = 400000,
  parameter int LEVEL_SCORE = 5,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pb,
  input  logic       pause_pb,
  input  logic       good_coll,
  input  logic       bad_coll,
  input  logic       game_complete,
  output logic [1:0] state,
  output logic       sync_reset,
  output logic       move_tick,
  output logic       play_en,
  output logic       game_over,
  output logic [3:0] level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;
  localparam int PW = CNT_W + 4;

  logic [1:0]       r_start_sync;
  logic [1:0]       r_pause_sync;
  logic             r_start_prev;
  logic             r_pause_prev;
  logic             w_start_p;
  logic             w_pause_p;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_sync_reset;
  logic             r_move_tick;
  logic             r_play_en;
  logic             r_game_over;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_level;
  logic [PW-1:0]    w_dec;
  logic [PW-1:0]    w_period;
  logic             w_term;

  // Buttons: two-flop synchronizer, then a registered previous value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_sync <= 2'b00;
      r_pause_sync <= 2'b00;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], start_pb};
      r_pause_sync <= {r_pause_sync[0], pause_pb};
      r_start_prev <= r_start_sync[1];
      r_pause_prev <= r_pause_sync[1];
    end
  end

  assign w_start_p = r_start_sync[1] & ~r_start_prev;
  assign w_pause_p = r_pause_sync[1] & ~r_pause_prev;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_p) w_next = S_PLAY;
      S_PLAY: begin
        if (bad_coll || game_complete) w_next = S_OVER;
        else if (w_pause_p)            w_next = S_PAUSE;
      end
      S_PAUSE: if (w_pause_p || w_start_p) w_next = S_PLAY;
      default: if (w_start_p) w_next = S_IDLE;
    endcase
  end

  // Decodes are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sync_reset <= 1'b0;
      r_play_en    <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_sync_reset <= (r_state == S_IDLE) && (w_next == S_PLAY);
      r_play_en    <= (w_next == S_PLAY);
      r_game_over  <= (w_next == S_OVER);
    end
  end

`ifdef GFC_SPEEDUP_EN
  localparam int AW = (LEVEL_SCORE > 1) ? $clog2(LEVEL_SCORE) : 1;

  logic [AW-1:0] r_apple;
  logic [3:0]    r_level;
  logic          w_apple_inc;

  // A fatal collision in the same cycle wins over the apple
  assign w_apple_inc = good_coll && !bad_coll && (r_state == S_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_apple <= '0;
      r_level <= 4'd0;
    end else if ((r_state == S_OVER) && w_start_p) begin
      r_apple <= '0;
      r_level <= 4'd0;
    end else if (w_apple_inc) begin
      if (r_apple == AW'(LEVEL_SCORE - 1)) begin
        r_apple <= '0;
        if (r_level != 4'hF) r_level <= r_level + 4'd1;
      end else begin
        r_apple <= r_apple + AW'(1);
      end
    end
  end

  assign w_level = r_level;
`else
  logic w_unused_cfg;

  // Apple count only matters when the speedup is built in
  assign w_unused_cfg = (LEVEL_SCORE > 0);
  assign w_level      = 4'd0;
`endif

  // max(TICK_BASE - level*TICK_STEP, TICK_MIN) without going below zero
  assign w_dec    = PW'(w_level) * PW'(TICK_STEP);
  assign w_period = ((w_dec + PW'(TICK_MIN)) >= PW'(TICK_BASE)) ? PW'(TICK_MIN)
                                                                 : (PW'(TICK_BASE) - w_dec);
  assign w_term   = ({4'd0, r_cnt} >= (w_period - PW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_move_tick <= 1'b0;
    end else begin
      r_move_tick <= 1'b0;
      if ((r_state == S_PLAY) && (w_next == S_PLAY)) begin
        if (w_term) begin
          r_cnt       <= '0;
          r_move_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if ((r_state == S_PLAY) && (w_next == S_PAUSE)) begin
        // A due tick is held over and fires on the first cycle after resume
        if (!w_term) r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state != S_PAUSE) begin
        r_cnt <= '0;
      end
    end
  end

  assign state      = r_state;
  assign sync_reset = r_sync_reset;
  assign move_tick  = r_move_tick;
  assign play_en    = r_play_en;
  assign game_over  = r_game_over;
  assign level      = w_level;

endmodule
